// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sha256_pkg
// Description : SHA-256 constants, round helper functions and the sweeper's
//               FSM state encoding.
// Revision    : 1.0
// ============================================================================
package sha256_pkg;

    localparam logic [31:0] PAD_WORD = 32'h80000000;
    localparam logic [31:0] LEN_640  = 32'h00000280;

    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ROUND = 2'd2,
        S_FINAL = 2'd3
    } state_t;

    function automatic logic [31:0] k_rom(input logic [5:0] t);
        return K_ROM[t];
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_round.sv
`default_nettype none
// ============================================================================
// Module      : sha256_round
// Description : One combinational SHA-256 compression round; state packed
//               as {a,b,c,d,e,f,g,h} with a in the top word.
// Revision    : 1.0
// ============================================================================
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] i_state,
    input  logic [31:0]  i_k,
    input  logic [31:0]  i_w,
    output logic [255:0] o_state
);

    logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
    logic [31:0] w_t1, w_t2;

    assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_state;

    assign w_t1 = w_h + big_sigma1(w_e) + ch(w_e, w_f, w_g) + i_k + i_w;
    assign w_t2 = big_sigma0(w_a) + maj(w_a, w_b, w_c);

    assign o_state = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};

endmodule
`default_nettype wire

// File: rtl/nonce_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : nonce_sweeper
// Description : Iterative SHA-256 second-chunk compressor sweeping a nonce
//               range until a digest with DIFF_BITS leading zeros appears.
// Revision    : 1.0
// ============================================================================
module nonce_sweeper
    import sha256_pkg::*;
#(
    parameter int unsigned DIFF_BITS = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [255:0] h_prev,
    input  logic [95:0]  m_tail,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic         abort,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [31:0]  found_nonce,
    output logic [255:0] digest,
    output logic [31:0]  nonce_cur
);

    // Zero bits of the mask are don't-care; DIFF_BITS=0 yields an all-zero mask.
    localparam logic [255:0] c_hit_mask = ~({256{1'b1}} >> DIFF_BITS);

    state_t       r_state, w_state_nxt;
    logic [255:0] r_hprev, r_work, w_work_nxt, w_digest;
    logic [95:0]  r_tail;
    logic [31:0]  r_nend, r_ncur;
    logic [31:0]  r_w [16];
    logic [31:0]  w_w_new, w_k;
    logic [5:0]   r_t;
    logic         w_hit, w_last;
    logic         r_busy, r_done, r_found;
    logic [31:0]  r_found_nonce;
    logic [255:0] r_digest;

    assign w_k     = k_rom(r_t);
    assign w_w_new = small_sigma1(r_w[14]) + r_w[9] + small_sigma0(r_w[1]) + r_w[0];
    assign w_hit   = ((w_digest & c_hit_mask) == '0);
    assign w_last  = (r_ncur == r_nend);

    sha256_round u_round (
        .i_state (r_work),
        .i_k     (w_k),
        .i_w     (r_w[0]),
        .o_state (w_work_nxt)
    );

    for (genvar gi = 0; gi < 8; gi++) begin : g_digest
        assign w_digest[gi*32 +: 32] = r_hprev[gi*32 +: 32] + r_work[gi*32 +: 32];
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_ROUND;
            S_ROUND: if (r_t == 6'd63) w_state_nxt = S_FINAL;
            S_FINAL: w_state_nxt = (w_hit || w_last) ? S_IDLE : S_LOAD;
            default: w_state_nxt = S_IDLE;
        endcase
        // abort dominates everything, including a simultaneous start in IDLE
        if (abort) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hprev       <= '0;
            r_tail        <= '0;
            r_nend        <= '0;
            r_ncur        <= '0;
            r_work        <= '0;
            r_t           <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_found       <= 1'b0;
            r_found_nonce <= '0;
            r_digest      <= '0;
            for (int i = 0; i < 16; i++) r_w[i] <= '0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_busy <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: if (start) begin
                        r_hprev <= h_prev;
                        r_tail  <= m_tail;
                        r_nend  <= nonce_end;
                        r_ncur  <= nonce_start;
                        r_found <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                    S_LOAD: begin
                        r_work <= r_hprev;
                        r_t    <= '0;
                        r_w[0] <= r_tail[95:64];
                        r_w[1] <= r_tail[63:32];
                        r_w[2] <= r_tail[31:0];
                        r_w[3] <= r_ncur;
                        r_w[4] <= PAD_WORD;
                        for (int i = 5; i < 15; i++) r_w[i] <= '0;
                        r_w[15] <= LEN_640;
                    end
                    S_ROUND: begin
                        r_work <= w_work_nxt;
                        r_t    <= r_t + 6'd1;
                        for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
                        r_w[15] <= w_w_new;
                    end
                    S_FINAL: begin
                        r_digest <= w_digest;
                        if (w_hit) begin
                            r_found       <= 1'b1;
                            r_found_nonce <= r_ncur;
                            r_done        <= 1'b1;
                            r_busy        <= 1'b0;
                        end else if (w_last) begin
                            r_done <= 1'b1;
                            r_busy <= 1'b0;
                        end else begin
                            r_ncur <= r_ncur + 32'd1;
                        end
                    end
                    default: r_busy <= 1'b0;
                endcase
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign found       = r_found;
    assign found_nonce = r_found_nonce;
    assign digest      = r_digest;
    assign nonce_cur   = r_ncur;

endmodule
`default_nettype wire

// File: tb/tb_nonce_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_nonce_sweeper
// Description : Self-checking bench; three sweepers (DIFF_BITS 0, 8, 255)
//               share stimulus and are scored against a SHA-256 model.
// Revision    : 1.0
// ============================================================================
module tb_nonce_sweeper;
    import sha256_pkg::*;

    typedef struct {
        logic         fnd;
        logic [31:0]  non;
        logic [255:0] dig;
        int           cyc;
    } exp_t;

    typedef struct {
        logic [255:0] h;
        logic [95:0]  tail;
        logic [31:0]  ns;
        logic [31:0]  ne;
        int           max_cyc;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, start, abort;
    logic [255:0] h_prev;
    logic [95:0]  m_tail;
    logic [31:0]  nonce_start, nonce_end;
    logic [2:0]   busy_v, done_v, found_v;
    logic [31:0]  fn_v  [3];
    logic [255:0] dig_v [3];
    logic [31:0]  cur_v [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        nonce_sweeper #(.DIFF_BITS(g == 0 ? 0 : (g == 1 ? 8 : 255))) u_dut (
            .clk         (clk),
            .reset       (reset),
            .start       (start),
            .h_prev      (h_prev),
            .m_tail      (m_tail),
            .nonce_start (nonce_start),
            .nonce_end   (nonce_end),
            .abort       (abort),
            .busy        (busy_v[g]),
            .done        (done_v[g]),
            .found       (found_v[g]),
            .found_nonce (fn_v[g]),
            .digest      (dig_v[g]),
            .nonce_cur   (cur_v[g])
        );
    end

    int   chk_cnt = 0;
    int   err_cnt = 0;
    int   cyc = 0;
    int   t0 = 0;
    exp_t sb [3][$];
    logic [2:0] prev_done = 3'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] req);
        chk_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] m_compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] s0, s1, t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        for (int i = 0; i < 8; i++) v[i] = h[255-32*i -: 32];
        for (int i = 0; i < 64; i++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_ROM[i] + w[i];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = h[255-32*i -: 32] + v[i];
        return r;
    endfunction

    function automatic logic [511:0] chunk(input logic [95:0] tail, input logic [31:0] n);
        return {tail, n, 32'h80000000, 320'd0, 32'h00000280};
    endfunction

    function automatic logic is_hit(input int diff, input logic [255:0] d);
        if (diff == 0) return 1'b1;
        return ((d >> (256 - diff)) == '0);
    endfunction

    function automatic exp_t predict(input int diff, input logic [255:0] h, input logic [95:0] tail,
                                     input logic [31:0] ns, input logic [31:0] ne);
        exp_t e;
        logic [31:0] n;
        n = ns; e.fnd = 1'b0; e.non = '0; e.dig = '0; e.cyc = 0;
        for (int i = 0; i < 100000; i++) begin
            e.dig = m_compress(h, chunk(tail, n));
            e.cyc += 66;
            if (is_hit(diff, e.dig)) begin e.fnd = 1'b1; e.non = n; break; end
            if (n == ne) break;
            n = n + 32'd1;
        end
        return e;
    endfunction

    function automatic vec_t mk_vec(input logic [255:0] h, input logic [95:0] tail,
                                    input logic [31:0] ns, input logic [31:0] ne, input int mc);
        vec_t v;
        v.h = h; v.tail = tail; v.ns = ns; v.ne = ne; v.max_cyc = mc;
        return v;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (prev_done[k]) begin
                check($sformatf("d%0d_after_done_busy_done", k), {254'd0, busy_v[k], done_v[k]}, 256'd0);
            end
            if (done_v[k]) begin
                if (sb[k].size() == 0) begin
                    chk_cnt++; err_cnt++;
                    $display("FAIL d%0d_unexpected_done: got done=1 required done=0 at rel cycle %0d", k, cyc - t0 - 1);
                end else begin
                    e = sb[k].pop_front();
                    check($sformatf("d%0d_found", k), 256'(found_v[k]), 256'(e.fnd));
                    if (e.fnd) check($sformatf("d%0d_found_nonce", k), 256'(fn_v[k]), 256'(e.non));
                    check($sformatf("d%0d_digest", k), dig_v[k], e.dig);
                    check($sformatf("d%0d_done_cycle", k), 256'(cyc - t0 - 1), 256'(e.cyc));
                end
            end
        end
        prev_done = done_v;
    end

    task automatic drive_start(input vec_t v);
        @(negedge clk);
        h_prev = v.h; m_tail = v.tail; nonce_start = v.ns; nonce_end = v.ne;
        start = 1'b1;
        t0 = cyc;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        drive_start(v);
        e.fnd = 1'b1; e.non = v.ns; e.dig = m_compress(v.h, chunk(v.tail, v.ns)); e.cyc = 66;
        sb[0].push_back(e);
        sb[1].push_back(predict(8, v.h, v.tail, v.ns, v.ne));
        e.fnd = 1'b0; e.non = '0; e.dig = m_compress(v.h, chunk(v.tail, v.ne)); e.cyc = v.max_cyc;
        sb[2].push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk_cnt++;
        if (n >= budget) begin
            err_cnt++;
            $display("FAIL wait_done: got timeout after %0d cycles required all done pulses", budget);
            for (int k = 0; k < 3; k++) sb[k].delete();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_d%0d_flags", tag, k), {253'd0, busy_v[k], done_v[k], found_v[k]}, 256'd0);
            check($sformatf("%s_d%0d_found_nonce", tag, k), 256'(fn_v[k]), 256'd0);
            check($sformatf("%s_d%0d_digest", tag, k), dig_v[k], 256'd0);
            check($sformatf("%s_d%0d_nonce_cur", tag, k), 256'(cur_v[k]), 256'd0);
        end
    endtask

    initial begin
        vec_t         vt [3];
        vec_t         v;
        exp_t         e;
        logic [95:0]  tail8;
        logic [31:0]  n_hit;
        logic [31:0]  wexp [4];
        logic [255:0] dig_keep;

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        h_prev = '0; m_tail = '0; nonce_start = '0; nonce_end = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");

        // model sanity: compression of the one-block message "abc"
        check("model_kat_abc", m_compress(SHA256_IV, {32'h61626380, 448'd0, 32'h00000018}),
              256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

        // find a nonce N>=3 whose digest has 8 leading zeros and N-3..N-1 do not
        tail8 = 96'h0123456789abcdef0badf00d;
        n_hit = '0;
        for (int n = 3; n < 5000 && n_hit == 0; n++) begin
            if (is_hit(8, m_compress(SHA256_IV, chunk(tail8, 32'(n)))) &&
                !is_hit(8, m_compress(SHA256_IV, chunk(tail8, 32'(n - 1)))) &&
                !is_hit(8, m_compress(SHA256_IV, chunk(tail8, 32'(n - 2)))) &&
                !is_hit(8, m_compress(SHA256_IV, chunk(tail8, 32'(n - 3)))))
                n_hit = 32'(n);
        end
        chk_cnt++;
        if (n_hit == 0) begin
            err_cnt++;
            $display("FAIL vector_search: got no hit nonce required one below 5000");
            n_hit = 32'd3;
        end

        vt[0] = mk_vec(SHA256_IV, 96'h0, 32'd5, 32'd9, 330);
        vt[1] = mk_vec(SHA256_IV, 96'h1, 32'd0, 32'd2, 198);
        vt[2] = mk_vec(SHA256_IV, tail8, n_hit - 32'd3, n_hit + 32'd10, 924);

        for (int i = 0; i < 3; i++) begin
            run_vec(vt[i]);
            wait_idle(2000);
        end

        // wrap-around sweep with nonce_cur trace
        wexp[0] = 32'hFFFFFFFE; wexp[1] = 32'hFFFFFFFF; wexp[2] = 32'h0; wexp[3] = 32'h1;
        run_vec(mk_vec(SHA256_IV, 96'h1, 32'hFFFFFFFE, 32'h00000001, 264));
        for (int i = 0; i < 4; i++) begin
            while (cyc - t0 - 1 < 33 + 66 * i) @(negedge clk);
            check($sformatf("wrap_nonce_cur_%0d", i), 256'(cur_v[2]), 256'(wexp[i]));
        end
        wait_idle(2000);

        // abort in the middle of a long sweep; ignored start while busy
        v = mk_vec(SHA256_IV, 96'h0, 32'd0, 32'd1000, 0);
        drive_start(v);
        e.fnd = 1'b1; e.non = 32'd0; e.dig = m_compress(SHA256_IV, chunk(96'h0, 32'd0)); e.cyc = 66;
        sb[0].push_back(e);
        e = predict(8, SHA256_IV, 96'h0, 32'd0, 32'd1000);
        if (e.cyc < 100) sb[1].push_back(e);
        @(negedge clk);
        start = 1'b0;
        while (cyc - t0 - 1 < 80) @(negedge clk);
        start = 1'b1; nonce_start = 32'd777;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_nonce_cur", 256'(cur_v[2]), 256'd1);
        while (cyc - t0 - 1 < 99) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 256'(busy_v), 256'd0);
        check("abort_digest_held", dig_v[2], m_compress(SHA256_IV, chunk(96'h0, 32'd0)));
        check("abort_found_held", 256'(found_v[2]), 256'd0);
        dig_keep = dig_v[2];
        repeat (200) @(negedge clk);
        wait_idle(5);

        // start and abort together from IDLE: abort wins
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("start_abort_busy", 256'(busy_v), 256'd0);
        check("start_abort_digest", dig_v[2], dig_keep);

        // reset mid-ROUND, then a clean rerun of the first vector
        run_vec(vt[0]);
        while (cyc - t0 - 1 < 30) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) sb[k].delete();
        check_reset_vals("midreset");
        run_vec(vt[0]);
        wait_idle(2000);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
